// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI master arbiter.
// Contents:
//   arb_state_e  - sequencer FSM encoding (IDLE..GAP, 3 bits)
//   GNT_W        - width of gnt_id and of the round-robin pointer
//   TO_W         - width of the frame watchdog counter (used with SPI_ARB_TIMEOUT_EN)
//   nib_rev      - helper that reverses the nibble order of a 16-bit word
package spi_arb_pkg;

  localparam int unsigned GNT_W = 3;
  localparam int unsigned TO_W  = 13;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StWlow  = 3'd2,
    StWhigh = 3'd3,
    StResp  = 3'd4,
    StGap   = 3'd5
  } arb_state_e;

  function automatic logic [15:0] nib_rev(input logic [15:0] w);
    return {w[3:0], w[7:4], w[11:8], w[15:12]};
  endfunction

endpackage

// File: rtl/spi_master_arbiter_if.sv
// Bundle of the client handshake and SPI master signals around spi_master_arbiter.
// Modports:
//   master - arbiter side: consumes req/tx_dat/spi_load/spi_do,
//            drives ack/rx_dat/gnt_id/busy/err/spi_st/spi_di
//   slave  - environment side (clients plus SPI master), the mirror image
// Signals:
//   req[NREQ], tx_dat[NREQ*DW]  client requests and TX words (client i at [i*DW +: DW])
//   ack[NREQ], rx_dat[DW]       one-cycle frame-done pulse and received word
//   gnt_id[3], busy, err        status
//   spi_st, spi_di[DW]          start strobe and DI word to the SPI master
//   spi_load, spi_do[DW]        LOAD line and DO word from the SPI master
interface spi_master_arbiter_if
  import spi_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4,
  parameter int unsigned DW   = 16
) ();

  logic [NREQ-1:0]    req;
  logic [NREQ*DW-1:0] tx_dat;
  logic [NREQ-1:0]    ack;
  logic [DW-1:0]      rx_dat;
  logic [GNT_W-1:0]   gnt_id;
  logic               busy;
  logic               err;
  logic               spi_st;
  logic [DW-1:0]      spi_di;
  logic               spi_load;
  logic [DW-1:0]      spi_do;

  modport master (
    input  req, tx_dat, spi_load, spi_do,
    output ack, rx_dat, gnt_id, busy, err, spi_st, spi_di
  );

  modport slave (
    output req, tx_dat, spi_load, spi_do,
    input  ack, rx_dat, gnt_id, busy, err, spi_st, spi_di
  );

endinterface

// File: rtl/spi_rr_pick.sv
// Combinational round-robin picker.
// Searches req starting at ptr, then ptr+1 .. NREQ-1, wrapping to 0; the first set bit wins.
// Ports:
//   req   in  NREQ   request vector
//   ptr   in  GNT_W  search start index (< NREQ)
//   gnt   out GNT_W  index of the selected requester (0 when none)
//   valid out 1      at least one request is set
module spi_rr_pick
  import spi_arb_pkg::*;
#(
  parameter int unsigned NREQ = 4
) (
  input  logic [NREQ-1:0]  req,
  input  logic [GNT_W-1:0] ptr,
  output logic [GNT_W-1:0] gnt,
  output logic             valid
);

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    // Walk offsets in priority order; the inner loop keeps every req index constant.
    for (int unsigned off = 0; off < NREQ; off++) begin
      for (int unsigned j = 0; j < NREQ; j++) begin
        if (!valid && req[j] && (j == ((32'(ptr) + off) % NREQ))) begin
          valid = 1'b1;
          gnt   = GNT_W'(j);
        end
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin arbiter and sequencer in front of a shared SPI master.
// Grants one client, registers its TX word onto spi_di, pulses spi_st, follows the master
// LOAD line through one frame and returns the DO word with a one-cycle ack to that client,
// then forces GAP idle cycles before the next grant.
// Ports:
//   clk    system clock
//   clr_n  asynchronous reset, active low
//   bus    spi_master_arbiter_if.master (client req/tx_dat/ack/rx_dat, status, SPI side)
// Configuration macro:
//   SPI_ARB_TIMEOUT_EN - adds a frame watchdog of TO_CYC cycles; on expiry the frame is
//                        answered with rx_dat=0 and ack+err. Undefined: err is tied low and
//                        the FSM waits for LOAD indefinitely.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter int unsigned NREQ   = 4,
  parameter int unsigned DW     = 16,
  parameter int unsigned GAP    = 2,
  parameter int unsigned TO_CYC = 4096
) (
  input logic                 clk,
  input logic                 clr_n,
  spi_master_arbiter_if.master bus
);

  localparam int unsigned GapW = (GAP > 1) ? $clog2(GAP) : 1;

  if (NREQ < 2 || NREQ > 8 || GAP < 1 || TO_CYC < 1 || TO_CYC >= (1 << TO_W)) begin : g_cfg_check
    $error("spi_master_arbiter: unsupported parameter set");
  end

  arb_state_e       state_q, state_d;
  logic [GNT_W-1:0] gnt_q, gnt_d;
  logic [GNT_W-1:0] ptr_q, ptr_d;
  logic [DW-1:0]    spi_di_q, spi_di_d;
  logic [DW-1:0]    rx_dat_q, rx_dat_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
  logic             load_meta_q, load_sync_q;

  logic [GNT_W-1:0] pick_gnt;
  logic             pick_valid;
  logic [DW-1:0]    tx_sel;
  logic [NREQ-1:0]  ack;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            to_flag_q, to_flag_d;
  logic            timeout;
`endif

  spi_rr_pick #(
    .NREQ (NREQ)
  ) u_pick (
    .req   (bus.req),
    .ptr   (ptr_q),
    .gnt   (pick_gnt),
    .valid (pick_valid)
  );

  // Word of the client the picker selects this cycle.
  always_comb begin
    tx_sel = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (pick_gnt == GNT_W'(i)) begin
        tx_sel = bus.tx_dat[i*DW +: DW];
      end
    end
  end

  // LOAD crosses from the SPI clock domain; idle level is high.
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      load_meta_q <= 1'b1;
      load_sync_q <= 1'b1;
    end else begin
      load_meta_q <= bus.spi_load;
      load_sync_q <= load_meta_q;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  assign timeout = (to_cnt_q == TO_W'(TO_CYC - 1));
`endif

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    ptr_d     = ptr_q;
    spi_di_d  = spi_di_q;
    rx_dat_d  = rx_dat_q;
    gap_cnt_d = gap_cnt_q;
`ifdef SPI_ARB_TIMEOUT_EN
    to_cnt_d  = to_cnt_q;
    to_flag_d = to_flag_q;
`endif
    case (state_q)
      StIdle: begin
        if (pick_valid) begin
          gnt_d    = pick_gnt;
          spi_di_d = tx_sel;
          state_d  = StStart;
        end
      end
      StStart: begin
        state_d = StWlow;
`ifdef SPI_ARB_TIMEOUT_EN
        to_cnt_d  = '0;
        to_flag_d = 1'b0;
`endif
      end
      StWlow: begin
        // A LOAD that is already low (stuck master) lets this state pass at once.
        if (!load_sync_q) begin
          state_d = StWhigh;
`ifdef SPI_ARB_TIMEOUT_EN
        end else if (timeout) begin
          state_d   = StResp;
          rx_dat_d  = '0;
          to_flag_d = 1'b1;
`endif
        end
`ifdef SPI_ARB_TIMEOUT_EN
        to_cnt_d = to_cnt_q + TO_W'(1);
`endif
      end
      StWhigh: begin
        // Only reached after LOAD was seen low, so a high level here is the rising edge.
        if (load_sync_q) begin
          state_d  = StResp;
          rx_dat_d = bus.spi_do;
`ifdef SPI_ARB_TIMEOUT_EN
        end else if (timeout) begin
          state_d   = StResp;
          rx_dat_d  = '0;
          to_flag_d = 1'b1;
`endif
        end
`ifdef SPI_ARB_TIMEOUT_EN
        to_cnt_d = to_cnt_q + TO_W'(1);
`endif
      end
      StResp: begin
        state_d   = StGap;
        gap_cnt_d = '0;
        ptr_d     = (32'(gnt_q) == NREQ - 1) ? '0 : gnt_q + GNT_W'(1);
      end
      StGap: begin
        if (gap_cnt_q == GapW'(GAP - 1)) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      state_q   <= StIdle;
      gnt_q     <= '0;
      ptr_q     <= '0;
      spi_di_q  <= '0;
      rx_dat_q  <= '0;
      gap_cnt_q <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      ptr_q     <= ptr_d;
      spi_di_q  <= spi_di_d;
      rx_dat_q  <= rx_dat_d;
      gap_cnt_q <= gap_cnt_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      to_cnt_q  <= '0;
      to_flag_q <= 1'b0;
    end else begin
      to_cnt_q  <= to_cnt_d;
      to_flag_q <= to_flag_d;
    end
  end
`endif

  // Outputs are decoded from state so that reset clears them without waiting for a clock.
  always_comb begin
    ack = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      ack[i] = (state_q == StResp) && (gnt_q == GNT_W'(i));
    end
  end

  assign bus.ack    = ack;
  assign bus.rx_dat = rx_dat_q;
  assign bus.gnt_id = gnt_q;
  assign bus.busy   = (state_q != StIdle);
  assign bus.spi_st = (state_q == StStart);
  assign bus.spi_di = spi_di_q;

`ifdef SPI_ARB_TIMEOUT_EN
  assign bus.err = (state_q == StResp) && to_flag_q;
`else
  assign bus.err = 1'b0;
`endif

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Scoreboard bench for spi_master_arbiter: stimulus pushes expected ack records and expected
// start words into queues; a monitor pops and compares whenever ack or spi_st is presented.
module tb_spi_master_arbiter;
  import spi_arb_pkg::*;

  localparam int unsigned NREQ   = 4;
  localparam int unsigned DW     = 16;
  localparam int unsigned GAP    = 2;
  localparam int unsigned TO_CYC = 64;

  typedef struct packed {
    logic [3:0]  ack;
    logic [2:0]  gnt;
    logic [15:0] rx;
    logic        err;
  } exp_t;

  logic clk;
  logic clr_n;
  logic slave_en;

  int checks;
  int failures;
  int cyc;
  int st_cnt;
  int ack_cnt;
  bit err_seen;

  exp_t        exp_q[$];
  logic [15:0] di_q[$];

  spi_master_arbiter_if #(.NREQ(NREQ), .DW(DW)) bus ();

  spi_master_arbiter #(
    .NREQ   (NREQ),
    .DW     (DW),
    .GAP    (GAP),
    .TO_CYC (TO_CYC)
  ) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input int g, input logic [15:0] rx, input logic e);
    exp_t x;
    x.ack = 4'b0001 << g;
    x.gnt = 3'(g);
    x.rx  = rx;
    x.err = e;
    exp_q.push_back(x);
  endtask

  task automatic set_tx(input int i, input logic [15:0] v);
    bus.tx_dat[i*DW +: DW] = v;
  endtask

  task automatic wait_ack(input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (|bus.ack) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL ack_timeout actual=no_ack expected=ack_within_%0d (t=%0t)", max, $time);
    end
  endtask

  task automatic wait_load_low(input int max);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max && !seen; i++) begin
      @(negedge clk);
      if (bus.spi_load === 1'b0) seen = 1'b1;
    end
    if (!seen) begin
      checks++;
      failures++;
      $display("FAIL load_low_timeout actual=high expected=low_within_%0d (t=%0t)", max, $time);
    end
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1 clr_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 clr_n = 1'b1;
  endtask

  // SPI master model: answers each start with the nibble-reversed DI word.
  initial begin
    logic [15:0] d;
    bus.spi_load = 1'b1;
    bus.spi_do   = '0;
    forever begin
      @(negedge clk);
      if (slave_en && bus.spi_st === 1'b1) begin
        d = bus.spi_di;
        repeat (2) @(posedge clk);
        #1 bus.spi_load = 1'b0;
        repeat (8) @(posedge clk);
        #1 bus.spi_do = nib_rev(d);
        bus.spi_load = 1'b1;
      end
    end
  end

  // Monitor / scoreboard.
  initial begin
    exp_t        e;
    logic [15:0] d;
    int          last_ack;
    bit          have_last;
    have_last = 1'b0;
    last_ack  = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (clr_n === 1'b1) begin
        if (bus.err === 1'b1) err_seen = 1'b1;
        if (bus.spi_st === 1'b1) begin
          st_cnt++;
          if (di_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_start actual=spi_di_%0h expected=no_start", bus.spi_di);
          end else begin
            d = di_q.pop_front();
            chk("spi_di_at_start", 32'(bus.spi_di), 32'(d));
          end
        end
        if (|bus.ack) begin
          ack_cnt++;
          if (have_last) chk("ack_spacing", 32'((cyc - last_ack) >= int'(GAP + 1)), 32'd1);
          have_last = 1'b1;
          last_ack  = cyc;
          if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_ack actual=%0h expected=none", bus.ack);
          end else begin
            e = exp_q.pop_front();
            chk("ack_vector", 32'(bus.ack), 32'(e.ack));
            chk("gnt_id", 32'(bus.gnt_id), 32'(e.gnt));
            chk("rx_dat", 32'(bus.rx_dat), 32'(e.rx));
            chk("err_with_ack", 32'(bus.err), 32'(e.err));
          end
        end
      end
    end
  end

  initial begin
    int st_before;
    int ack_before;
    clr_n    = 1'b0;
    slave_en = 1'b1;
    bus.req  = '0;
    bus.tx_dat = '0;

    // Reset values.
    repeat (3) @(negedge clk);
    chk("rst_ack", 32'(bus.ack), 32'd0);
    chk("rst_rx_dat", 32'(bus.rx_dat), 32'd0);
    chk("rst_gnt_id", 32'(bus.gnt_id), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_spi_st", 32'(bus.spi_st), 32'd0);
    chk("rst_spi_di", 32'(bus.spi_di), 32'd0);
    @(posedge clk);
    #1 clr_n = 1'b1;

    // 1. Single client with loopback slave.
    st_before = st_cnt;
    set_tx(0, 16'hA5C3);
    push_exp(0, 16'h3C5A, 1'b0);
    di_q.push_back(16'hA5C3);
    @(posedge clk);
    #1 bus.req = 4'b0001;
    @(negedge clk);
    chk("st_not_yet", 32'(bus.spi_st), 32'd0);
    @(negedge clk);
    chk("st_latency", 32'(bus.spi_st), 32'd1);
    wait_ack(100);
    bus.req = '0;
    repeat (GAP + 4) @(negedge clk);
    chk("single_st_pulse", 32'(st_cnt - st_before), 32'd1);
    chk("idle_after_gap", 32'(bus.busy), 32'd0);

    // 2. All four held: grants 0,1,2,3,0.
    do_reset();
    set_tx(0, 16'h1234);
    set_tx(1, 16'h5678);
    set_tx(2, 16'h9ABC);
    set_tx(3, 16'hDEF0);
    push_exp(0, 16'h4321, 1'b0); di_q.push_back(16'h1234);
    push_exp(1, 16'h8765, 1'b0); di_q.push_back(16'h5678);
    push_exp(2, 16'hCBA9, 1'b0); di_q.push_back(16'h9ABC);
    push_exp(3, 16'h0FED, 1'b0); di_q.push_back(16'hDEF0);
    push_exp(0, 16'h4321, 1'b0); di_q.push_back(16'h1234);
    @(posedge clk);
    #1 bus.req = 4'b1111;
    for (int k = 0; k < 5; k++) wait_ack(100);
    bus.req = '0;
    repeat (GAP + 4) @(negedge clk);

    // 3. Client 2 drops req during WHIGH; ack still comes, next grant is 3.
    do_reset();
    set_tx(2, 16'h0F1E);
    set_tx(3, 16'hC0DE);
    push_exp(2, 16'hE1F0, 1'b0); di_q.push_back(16'h0F1E);
    push_exp(3, 16'hED0C, 1'b0); di_q.push_back(16'hC0DE);
    @(posedge clk);
    #1 bus.req = 4'b1100;
    wait_load_low(50);
    repeat (3) @(negedge clk);
    bus.req[2] = 1'b0;
    wait_ack(100);
    wait_ack(100);
    bus.req = '0;
    repeat (GAP + 4) @(negedge clk);

    // 4. Reset during WHIGH, then a clean frame to client 1.
    do_reset();
    set_tx(1, 16'h8001);
    set_tx(3, 16'h4242);
    di_q.push_back(16'h4242);
    @(posedge clk);
    #1 bus.req = 4'b1000;
    wait_load_low(50);
    repeat (3) @(negedge clk);
    @(posedge clk);
    #1 clr_n = 1'b0;
    #1;
    chk("midrst_ack", 32'(bus.ack), 32'd0);
    chk("midrst_busy", 32'(bus.busy), 32'd0);
    chk("midrst_spi_di", 32'(bus.spi_di), 32'd0);
    chk("midrst_gnt_id", 32'(bus.gnt_id), 32'd0);
    chk("midrst_spi_st", 32'(bus.spi_st), 32'd0);
    bus.req = '0;
    repeat (20) @(posedge clk);
    #1 clr_n = 1'b1;
    repeat (2) @(posedge clk);
    push_exp(1, 16'h1008, 1'b0);
    di_q.push_back(16'h8001);
    #1 bus.req = 4'b0010;
    wait_ack(100);
    bus.req = '0;
    repeat (GAP + 4) @(negedge clk);

    // 5/6. Master never frames: LOAD stays high.
    do_reset();
    slave_en = 1'b0;
    set_tx(0, 16'h7777);
    di_q.push_back(16'h7777);
    ack_before = ack_cnt;
`ifdef SPI_ARB_TIMEOUT_EN
    push_exp(0, 16'h0000, 1'b1);
    @(posedge clk);
    #1 bus.req = 4'b0001;
    wait_ack(TO_CYC + 50);
    bus.req = '0;
    repeat (GAP + 2) @(negedge clk);
    chk("timeout_back_idle", 32'(bus.busy), 32'd0);
    chk("timeout_one_ack", 32'(ack_cnt - ack_before), 32'd1);
`else
    @(posedge clk);
    #1 bus.req = 4'b0001;
    repeat (200) @(negedge clk);
    chk("stuck_busy", 32'(bus.busy), 32'd1);
    chk("stuck_no_ack", 32'(ack_cnt - ack_before), 32'd0);
    chk("err_never", 32'(err_seen), 32'd0);
    bus.req = '0;
`endif
    do_reset();
    slave_en = 1'b1;
    repeat (4) @(negedge clk);

    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("di_q_drained", 32'(di_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
